// File: rtl/wbaq_pkg.sv
// Shared types and constants for the writeback address queue (wbaq_ctrl).
package wbaq_pkg;

  localparam int WBAQ_DEPTH = 8;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int SIZE_W  = 2;
  localparam int PTCID_W = 7;
  localparam int ENTRY_W = ADDR_W + DATA_W + SIZE_W + PTCID_W;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } wbaq_size_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [SIZE_W-1:0]  size;
    logic [PTCID_W-1:0] ptcid;
  } entry_t;

  // A load may only take data from a store of identical address and size.
  function automatic logic entry_match(input entry_t e,
                                       input logic [ADDR_W-1:0] addr,
                                       input logic [SIZE_W-1:0] size);
    return (e.addr == addr) && (e.size == size);
  endfunction

endpackage

// File: rtl/wbaq_ptr.sv
// Wrapping queue pointer with increment enable and asynchronous clear.
module wbaq_ptr
  import wbaq_pkg::*;
#(
  parameter int DEPTH = WBAQ_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: explicit wrap from DEPTH-1 back to slot 0.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : (ptr_q + PW'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/wbaq_ctrl.sv
// Writeback memory-write queue feeding the D-cache write port, with optional
// store-to-load forwarding enabled by the WBAQ_FWD_EN macro.
module wbaq_ctrl
  import wbaq_pkg::*;
#(
  parameter int DEPTH = WBAQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  input  logic [31:0]            enq_addr,
  input  logic [63:0]            enq_data,
  input  logic [1:0]             enq_size,
  input  logic [6:0]             enq_ptcid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [31:0]            deq_addr,
  output logic [63:0]            deq_data,
  output logic [1:0]             deq_size,
  output logic [6:0]             deq_ptcid,
  output logic                   ovf_err,
  input  logic [31:0]            fwd_addr,
  input  logic [1:0]             fwd_size,
  output logic                   fwd_hit,
  output logic [63:0]            fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_s;
  logic [PW-1:0]    tail_s;
  logic             do_enq_s;
  logic             do_deq_s;
  logic [DEPTH-1:0] enq_mask_s;
  logic [DEPTH-1:0] deq_mask_s;
  entry_t           enq_entry_s;
  entry_t           head_entry_s;

  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           mem_q [DEPTH];

  // Occupancy flags are registered, so a same-cycle dequeue never frees a full slot.
  assign do_enq_s = enq_valid & ~full_q;
  assign do_deq_s = ~empty_q & deq_ready;

  wbaq_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .inc_i (do_deq_s),
    .ptr_o (head_s)
  );

  wbaq_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .inc_i (do_enq_s),
    .ptr_o (tail_s)
  );

  assign enq_entry_s = '{addr: enq_addr, data: enq_data, size: enq_size, ptcid: enq_ptcid};

  // Occupancy, flag and per-slot valid next-state.
  always_comb begin
    count_d = count_q;
    case ({do_enq_s, do_deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == CW'(0));
    ovf_d      = ovf_q | (enq_valid & full_q);
    enq_mask_s = do_enq_s ? (DEPTH'(1) << tail_s) : {DEPTH{1'b0}};
    deq_mask_s = do_deq_s ? (DEPTH'(1) << head_s) : {DEPTH{1'b0}};
    valid_d    = (valid_q | enq_mask_s) & ~deq_mask_s;
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      valid_q <= {DEPTH{1'b0}};
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage; stale payloads are harmless because every read is gated by valid.
  always_ff @(posedge clk) begin
    if (do_enq_s) begin
      mem_q[tail_s] <= enq_entry_s;
    end
  end

  assign head_entry_s = valid_q[head_s] ? mem_q[head_s] : '0;

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign ovf_err   = ovf_q;
  assign deq_valid = ~empty_q;
  assign deq_addr  = head_entry_s.addr;
  assign deq_data  = head_entry_s.data;
  assign deq_size  = head_entry_s.size;
  assign deq_ptcid = head_entry_s.ptcid;

`ifdef WBAQ_FWD_EN
  logic [PW-1:0] fwd_idx_s;
  logic          fwd_match_s;
  logic          fwd_hit_s;
  logic [63:0]   fwd_data_s;

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    fwd_idx_s   = head_s;
    fwd_match_s = 1'b0;
    fwd_hit_s   = 1'b0;
    fwd_data_s  = 64'd0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s   = head_s + PW'(i);
      fwd_match_s = valid_q[fwd_idx_s] & entry_match(mem_q[fwd_idx_s], fwd_addr, fwd_size);
      fwd_hit_s   = fwd_hit_s | fwd_match_s;
      fwd_data_s  = fwd_match_s ? mem_q[fwd_idx_s].data : fwd_data_s;
    end
  end

  assign fwd_hit  = fwd_hit_s;
  assign fwd_data = fwd_data_s;
`else
  logic unused_fwd_s;

  assign unused_fwd_s = ^{fwd_addr, fwd_size};
  assign fwd_hit      = 1'b0;
  assign fwd_data     = 64'd0;
`endif

endmodule

// File: tb/tb_wbaq_ctrl.sv
// Directed scoreboard bench for wbaq_ctrl; forwarding checks follow WBAQ_FWD_EN.
module tb_wbaq_ctrl;
  import wbaq_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [63:0] enq_data;
  logic [1:0]  enq_size;
  logic [6:0]  enq_ptcid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_addr;
  logic [63:0] deq_data;
  logic [1:0]  deq_size;
  logic [6:0]  deq_ptcid;
  logic        ovf_err;
  logic [31:0] fwd_addr;
  logic [1:0]  fwd_size;
  logic        fwd_hit;
  logic [63:0] fwd_data;

  int     checks;
  int     errors;
  logic   ovf_exp;
  entry_t sb [$];

  wbaq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_addr  (enq_addr),
    .enq_data  (enq_data),
    .enq_size  (enq_size),
    .enq_ptcid (enq_ptcid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_addr  (deq_addr),
    .deq_data  (deq_data),
    .deq_size  (deq_size),
    .deq_ptcid (deq_ptcid),
    .ovf_err   (ovf_err),
    .fwd_addr  (fwd_addr),
    .fwd_size  (fwd_size),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT state with the model, update the model, advance.
  task automatic tick();
    int     pre;
    entry_t e;
    pre = sb.size();
    chk("count", 128'(count), 128'(pre));
    chk("full", 128'(full), 128'(pre == DEPTH));
    chk("empty", 128'(empty), 128'(pre == 0));
    chk("deq_valid", 128'(deq_valid), 128'(pre != 0));
    chk("ovf_err", 128'(ovf_err), 128'(ovf_exp));
    if (pre == 0) begin
      chk("deq_idle_fields", 128'({deq_addr, deq_data, deq_size, deq_ptcid}), 128'(0));
    end else begin
      e = sb[0];
      chk("deq_head", 128'({deq_addr, deq_data, deq_size, deq_ptcid}),
          128'({e.addr, e.data, e.size, e.ptcid}));
      if (deq_ready) begin
        void'(sb.pop_front());
      end
    end
    if (enq_valid && pre == DEPTH) begin
      ovf_exp = 1'b1;
    end
    if (enq_valid && pre < DEPTH) begin
      sb.push_back('{addr: enq_addr, data: enq_data, size: enq_size, ptcid: enq_ptcid});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s,
                     input logic [6:0] p);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    enq_size  = s;
    enq_ptcid = p;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic drain();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk("drain_empty", 128'(empty), 128'(1));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ovf_exp   = 1'b0;
    rst       = 1'b1;
    enq_valid = 1'b0;
    enq_addr  = 32'd0;
    enq_data  = 64'd0;
    enq_size  = 2'd0;
    enq_ptcid = 7'd0;
    deq_ready = 1'b0;
    fwd_addr  = 32'h0000_2000;
    fwd_size  = 2'b10;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("rst_deq_fields", 128'({deq_addr, deq_data, deq_size, deq_ptcid}), 128'(0));
    chk("rst_fwd_hit", 128'(fwd_hit), 128'(0));
    chk("rst_fwd_data", 128'(fwd_data), 128'(0));
    chk("rst_ovf", 128'(ovf_err), 128'(0));
    rst = 1'b0;
    tick();

    // Single entry, one-cycle latency to deq_valid, then drain
    deq_ready = 1'b1;
    enq(32'h0000_1000, 64'hAA, 2'b11, 7'h05);
    chk("first_deq_valid", 128'(deq_valid), 128'(1));
    chk("first_deq_addr", 128'(deq_addr), 128'(32'h0000_1000));
    chk("first_deq_data", 128'(deq_data), 128'(64'hAA));
    chk("first_deq_size", 128'(deq_size), 128'(2'b11));
    tick();
    chk("first_empty_after", 128'(empty), 128'(1));

    // Fill, then overflow attempt
    deq_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      enq(32'h0000_3000 + 32'(i * 8), 64'h1111_0000 + 64'(i), 2'(i), 7'(i + 16));
    end
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_count", 128'(count), 128'(8));
    enq(32'hDEAD_0000, 64'hDEAD, 2'b11, 7'h7F);
    chk("ovf_set", 128'(ovf_err), 128'(1));
    chk("ovf_count", 128'(count), 128'(8));
    tick();
    chk("ovf_held", 128'(ovf_err), 128'(1));

    // Full with enq and deq together: dequeue only
    deq_ready = 1'b1;
    enq(32'hBEEF_0000, 64'hBEEF, 2'b01, 7'h33);
    chk("full_both_count", 128'(count), 128'(7));
    drain();

    // Twenty simultaneous enq/deq cycles across the wrap
    deq_ready = 1'b0;
    enq(32'h0000_4000, 64'h4000, 2'b10, 7'h01);
    deq_ready = 1'b1;
    enq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_addr  = 32'h0000_5000 + 32'(i * 4);
      enq_data  = {32'hC0DE_0000, 32'(i)};
      enq_size  = 2'(i + 1);
      enq_ptcid = 7'(i + 40);
      tick();
    end
    chk("pairs_count", 128'(count), 128'(1));
    drain();

    // Forwarding lookup: youngest matching entry wins, size must match exactly
    deq_ready = 1'b0;
    enq(32'h0000_2000, 64'h11, 2'b10, 7'h0A);
    enq(32'h0000_2000, 64'h22, 2'b10, 7'h0B);
    fwd_addr = 32'h0000_2000;
    fwd_size = 2'b10;
    #1;
`ifdef WBAQ_FWD_EN
    chk("fwd_hit", 128'(fwd_hit), 128'(1));
    chk("fwd_data", 128'(fwd_data), 128'(64'h22));
`else
    chk("fwd_hit_off", 128'(fwd_hit), 128'(0));
    chk("fwd_data_off", 128'(fwd_data), 128'(0));
`endif
    fwd_size = 2'b01;
    #1;
    chk("fwd_size_miss_hit", 128'(fwd_hit), 128'(0));
    chk("fwd_size_miss_data", 128'(fwd_data), 128'(0));
    fwd_size = 2'b10;
    drain();

    // Asynchronous reset with five entries pending
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq(32'h0000_6000 + 32'(i), 64'h6000 + 64'(i), 2'b00, 7'(i));
    end
    chk("pre_rst_count", 128'(count), 128'(5));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("async_rst_deq_fields", 128'({deq_addr, deq_data, deq_size, deq_ptcid}), 128'(0));
    chk("async_rst_fwd_hit", 128'(fwd_hit), 128'(0));
    chk("async_rst_ovf", 128'(ovf_err), 128'(0));
    sb.delete();
    ovf_exp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    deq_ready = 1'b1;
    repeat (3) tick();
    enq(32'h0000_7000, 64'h7777, 2'b11, 7'h44);
    chk("post_rst_deq_data", 128'(deq_data), 128'(64'h7777));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
